// File: rtl/alu_pipe.sv
// Registered ARM-style data-processing ALU: barrel shifter on B, 16 opcodes, NZCV flags, valid/ready both sides.
// Define ALU_PIPE_ROR_EN to enable rotate-right; otherwise ROR passes B through and flags err.
module alu_pipe #(
   parameter int WIDTH = 32,
   parameter int SHW   = $clog2(WIDTH)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [3:0]       op,
   input  logic             s_bit,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic [1:0]       sh_type,
   input  logic [SHW-1:0]   sh_amt,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] result,
   output logic             wb,
   output logic             err,
   output logic [3:0]       flags
);

   localparam logic [3:0] OP_AND = 4'h0, OP_EOR = 4'h1, OP_SUB = 4'h2, OP_RSB = 4'h3,
                          OP_ADD = 4'h4, OP_ADC = 4'h5, OP_SBC = 4'h6, OP_RSC = 4'h7,
                          OP_TST = 4'h8, OP_TEQ = 4'h9, OP_CMP = 4'hA, OP_CMN = 4'hB,
                          OP_ORR = 4'hC, OP_MOV = 4'hD, OP_BIC = 4'hE, OP_MVN = 4'hF;
   localparam logic [SHW:0] W_FULL = (SHW+1)'(WIDTH);

   logic             r_valid;
   logic [WIDTH-1:0] r_result;
   logic             r_wb;
   logic             r_err;
   logic [3:0]       r_flags;

   logic             w_accept;
   logic             w_c_cur;
   logic [WIDTH:0]   w_lsl_ext;
   logic [WIDTH:0]   w_lsr_ext;
   logic [WIDTH:0]   w_asr_ext;
   logic [SHW:0]     w_ror_amt;
   logic [WIDTH-1:0] w_ror;
   logic [WIDTH-1:0] w_sh_op;
   logic             w_sh_c;
   logic             w_sh_err;

   logic [WIDTH-1:0] w_x;
   logic [WIDTH-1:0] w_y;
   logic             w_cin;
   logic             w_arith;
   logic [WIDTH-1:0] w_logic_res;
   logic [WIDTH:0]   w_sum;
   logic [WIDTH-1:0] w_res;
   logic             w_c;
   logic             w_v;
   logic             w_cmp_op;
   logic             w_upd;

   assign in_ready = !rst && (!r_valid || out_ready);
   assign w_accept = in_valid && in_ready;
   assign w_c_cur  = r_flags[1];

   // Extended shifts keep the last bit shifted out at one end, which is the shifter carry.
   assign w_lsl_ext = {1'b0, b} << sh_amt;
   assign w_lsr_ext = {b, 1'b0} >> sh_amt;
   assign w_asr_ext = $signed({b, 1'b0}) >>> sh_amt;
   assign w_ror_amt = W_FULL - {1'b0, sh_amt};
   assign w_ror     = (b >> sh_amt) | (b << w_ror_amt);

   always_comb begin
      w_sh_op  = b;
      w_sh_c   = w_c_cur;
      w_sh_err = 1'b0;
      if (sh_amt != '0) begin
         case (sh_type)
            2'b00: begin w_sh_op = w_lsl_ext[WIDTH-1:0]; w_sh_c = w_lsl_ext[WIDTH]; end
            2'b01: begin w_sh_op = w_lsr_ext[WIDTH:1];   w_sh_c = w_lsr_ext[0];     end
            2'b10: begin w_sh_op = w_asr_ext[WIDTH:1];   w_sh_c = w_asr_ext[0];     end
            2'b11: begin
`ifdef ALU_PIPE_ROR_EN
               w_sh_op = w_ror;
               w_sh_c  = w_ror[WIDTH-1];
`endif
            end
            default: ;
         endcase
      end
`ifndef ALU_PIPE_ROR_EN
      w_sh_err = (sh_type == 2'b11);
`endif
   end

   always_comb begin
      w_x         = a;
      w_y         = w_sh_op;
      w_cin       = 1'b0;
      w_arith     = 1'b1;
      w_logic_res = '0;
      case (op)
         OP_SUB, OP_CMP: begin w_y = ~w_sh_op; w_cin = 1'b1; end
         OP_RSB:         begin w_x = w_sh_op; w_y = ~a; w_cin = 1'b1; end
         OP_ADD, OP_CMN: ;
         OP_ADC:         w_cin = w_c_cur;
         OP_SBC:         begin w_y = ~w_sh_op; w_cin = w_c_cur; end
         OP_RSC:         begin w_x = w_sh_op; w_y = ~a; w_cin = w_c_cur; end
         OP_AND, OP_TST: begin w_arith = 1'b0; w_logic_res = a & w_sh_op; end
         OP_EOR, OP_TEQ: begin w_arith = 1'b0; w_logic_res = a ^ w_sh_op; end
         OP_ORR:         begin w_arith = 1'b0; w_logic_res = a | w_sh_op; end
         OP_MOV:         begin w_arith = 1'b0; w_logic_res = w_sh_op; end
         OP_BIC:         begin w_arith = 1'b0; w_logic_res = a & ~w_sh_op; end
         OP_MVN:         begin w_arith = 1'b0; w_logic_res = ~w_sh_op; end
         default:        w_arith = 1'b0;
      endcase
   end

   assign w_sum = {1'b0, w_x} + {1'b0, w_y} + {{WIDTH{1'b0}}, w_cin};

   always_comb begin
      w_res = w_logic_res;
      w_c   = w_sh_c;
      w_v   = r_flags[0];
      if (w_arith) begin
         w_res = w_sum[WIDTH-1:0];
         w_c   = w_sum[WIDTH];
         w_v   = (w_x[WIDTH-1] == w_y[WIDTH-1]) && (w_sum[WIDTH-1] != w_x[WIDTH-1]);
      end
   end

   assign w_cmp_op = (op[3:2] == 2'b10);
   assign w_upd    = w_accept && (s_bit || w_cmp_op);

   always_ff @(posedge clk) begin
      if (rst) begin
         r_valid  <= 1'b0;
         r_result <= '0;
         r_wb     <= 1'b0;
         r_err    <= 1'b0;
         r_flags  <= 4'b0000;
      end else begin
         if (w_accept) begin
            r_valid  <= 1'b1;
            r_result <= w_res;
            r_wb     <= !w_cmp_op;
            r_err    <= w_sh_err;
         end else if (out_ready) begin
            r_valid  <= 1'b0;
         end
         if (w_upd) begin
            r_flags <= {w_res[WIDTH-1], (w_res == '0), w_c, w_v};
         end
      end
   end

   assign out_valid = r_valid;
   assign result    = r_result;
   assign wb        = r_wb;
   assign err       = r_err;
   assign flags     = r_flags;

endmodule

// File: tb/tb_alu_pipe.sv
// Self-checking bench for alu_pipe: directed scenarios plus randomized traffic against an arithmetic reference model.
module tb_alu_pipe;
   localparam longint MASK = 64'hFFFF_FFFF;
   localparam longint SMAX = 64'sd2147483647;
   localparam longint SMIN = -SMAX - 1;

   logic        clk = 1'b0;
   logic        rst, in_valid, in_ready, s_bit, out_valid, out_ready, wb, err;
   logic [3:0]  op, flags;
   logic [31:0] a, b, result;
   logic [1:0]  sh_type;
   logic [4:0]  sh_amt;

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   alu_pipe #(.WIDTH(32)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
      .op(op), .s_bit(s_bit), .a(a), .b(b), .sh_type(sh_type), .sh_amt(sh_amt),
      .out_valid(out_valid), .out_ready(out_ready), .result(result),
      .wb(wb), .err(err), .flags(flags)
   );

   function automatic void model(input logic [3:0] op_i, input logic s_i, input logic [31:0] a_i,
                                 input logic [31:0] b_i, input logic [1:0] sht_i, input logic [4:0] sha_i,
                                 input logic [3:0] fl_i, output logic [31:0] res_o, output logic wb_o,
                                 output logic err_o, output logic [3:0] fl_o);
      longint ua, ub, us, ur, sa, ss, sr, sb;
      int k, bw;
      logic cin, sc, c, v, arith;
      logic [31:0] sop;
      cin = fl_i[1]; k = int'(sha_i); bw = cin ? 0 : 1;
      ub = longint'({32'd0, b_i});
      sop = b_i; sc = cin; err_o = 1'b0;
      if (k != 0) begin
         case (sht_i)
            2'd0: begin sop = 32'((ub << k) & MASK); sc = ((ub >> (32 - k)) & 1) != 0; end
            2'd1: begin sop = 32'(ub >> k); sc = ((ub >> (k - 1)) & 1) != 0; end
            2'd2: begin
               sb = longint'($signed(b_i));
               sop = 32'((sb >>> k) & MASK); sc = ((ub >> (k - 1)) & 1) != 0;
            end
            default: begin
`ifdef ALU_PIPE_ROR_EN
               sop = 32'(((ub >> k) | (ub << (32 - k))) & MASK); sc = sop[31];
`endif
            end
         endcase
      end
`ifndef ALU_PIPE_ROR_EN
      if (sht_i == 2'd3) err_o = 1'b1;
`endif
      ua = longint'({32'd0, a_i}); us = longint'({32'd0, sop});
      sa = longint'($signed(a_i)); ss = longint'($signed(sop));
      arith = 1'b1; ur = 0; sr = 0; c = 1'b0;
      case (op_i)
         4'h2, 4'hA: begin ur = ua - us; c = (ua >= us); sr = sa - ss; end
         4'h3:       begin ur = us - ua; c = (us >= ua); sr = ss - sa; end
         4'h4, 4'hB: begin ur = ua + us; c = (ur > MASK); sr = sa + ss; end
         4'h5:       begin ur = ua + us + longint'(cin); c = (ur > MASK); sr = sa + ss + longint'(cin); end
         4'h6:       begin ur = ua - us - bw; c = (ua >= us + bw); sr = sa - ss - bw; end
         4'h7:       begin ur = us - ua - bw; c = (us >= ua + bw); sr = ss - sa - bw; end
         4'h0, 4'h8: begin arith = 1'b0; ur = ua & us; end
         4'h1, 4'h9: begin arith = 1'b0; ur = ua ^ us; end
         4'hC:       begin arith = 1'b0; ur = ua | us; end
         4'hD:       begin arith = 1'b0; ur = us; end
         4'hE:       begin arith = 1'b0; ur = ua & (MASK ^ us); end
         default:    begin arith = 1'b0; ur = MASK ^ us; end
      endcase
      res_o = 32'(ur & MASK);
      v = arith ? (sr > SMAX || sr < SMIN) : fl_i[0];
      if (!arith) c = sc;
      wb_o = !(op_i >= 4'h8 && op_i <= 4'hB);
      fl_o = (s_i || !wb_o) ? {res_o[31], res_o == 32'd0, c, v} : fl_i;
   endfunction

   task automatic drive(input logic [3:0] o, input logic s, input logic [31:0] av, input logic [31:0] bv,
                        input logic [1:0] st, input logic [4:0] sa);
      op = o; s_bit = s; a = av; b = bv; sh_type = st; sh_amt = sa; in_valid = 1'b1;
   endtask

   task automatic test_reset;
      rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
      drive(4'h4, 1'b0, 32'd0, 32'd0, 2'd0, 5'd0); in_valid = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL rst_valid got %b exp 0", out_valid); end
      n_checks++; if (result !== 32'd0) begin n_fail++; $display("FAIL rst_result got %h exp 0", result); end
      n_checks++; if (flags !== 4'b0000) begin n_fail++; $display("FAIL rst_flags got %b exp 0000", flags); end
      n_checks++; if ({wb, err} !== 2'b00) begin n_fail++; $display("FAIL rst_wb_err got %b exp 00", {wb, err}); end
      in_valid = 1'b1;
      #1;
      n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL rst_in_ready_hi got %b exp 0", in_ready); end
      in_valid = 1'b0;
      @(posedge clk); #1;
      n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL rst_no_accept got %b exp 0", out_valid); end
      rst = 1'b0;
      #1;
      n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL rst_ready_after got %b exp 1", in_ready); end
   endtask

   task automatic test_add_drain;
      drive(4'h4, 1'b1, 32'hFFFF_FFFF, 32'h1, 2'd0, 5'd0);
      @(posedge clk); #1;
      in_valid = 1'b0;
      n_checks++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL add_valid got %b exp 1", out_valid); end
      n_checks++; if (result !== 32'h0) begin n_fail++; $display("FAIL add_result got %h exp 0", result); end
      n_checks++; if (wb !== 1'b1) begin n_fail++; $display("FAIL add_wb got %b exp 1", wb); end
      n_checks++; if (flags !== 4'b0110) begin n_fail++; $display("FAIL add_flags got %b exp 0110", flags); end
      @(posedge clk); #1;
      n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL drain_valid got %b exp 0", out_valid); end
      n_checks++; if (result !== 32'h0) begin n_fail++; $display("FAIL drain_hold got %h exp 0", result); end
   endtask

   task automatic test_back_to_back;
      drive(4'h4, 1'b1, 32'h7FFF_FFFF, 32'h1, 2'd0, 5'd0);
      @(posedge clk); #1;
      n_checks++; if (result !== 32'h8000_0000) begin n_fail++; $display("FAIL b2b_add_res got %h exp 80000000", result); end
      n_checks++; if (flags !== 4'b1001) begin n_fail++; $display("FAIL b2b_add_flags got %b exp 1001", flags); end
      drive(4'h5, 1'b1, 32'h0, 32'h0, 2'd0, 5'd0);
      #1;
      n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL b2b_ready got %b exp 1", in_ready); end
      @(posedge clk); #1;
      in_valid = 1'b0;
      n_checks++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL b2b_valid got %b exp 1", out_valid); end
      n_checks++; if (result !== 32'h0) begin n_fail++; $display("FAIL b2b_adc_res got %h exp 0", result); end
      n_checks++; if (flags !== 4'b0100) begin n_fail++; $display("FAIL b2b_adc_flags got %b exp 0100", flags); end
      @(posedge clk); #1;
   endtask

   task automatic test_cmp_sbc;
      drive(4'hA, 1'b0, 32'd5, 32'd7, 2'd0, 5'd0);
      @(posedge clk); #1;
      n_checks++; if (wb !== 1'b0) begin n_fail++; $display("FAIL cmp_wb got %b exp 0", wb); end
      n_checks++; if (result !== 32'hFFFF_FFFE) begin n_fail++; $display("FAIL cmp_res got %h exp fffffffe", result); end
      n_checks++; if (flags !== 4'b1000) begin n_fail++; $display("FAIL cmp_flags got %b exp 1000", flags); end
      drive(4'h6, 1'b1, 32'd10, 32'd3, 2'd0, 5'd0);
      @(posedge clk); #1;
      in_valid = 1'b0;
      n_checks++; if (result !== 32'd6) begin n_fail++; $display("FAIL sbc_res got %h exp 6", result); end
      n_checks++; if (flags !== 4'b0010) begin n_fail++; $display("FAIL sbc_flags got %b exp 0010", flags); end
      @(posedge clk); #1;
   endtask

   task automatic test_shift;
      drive(4'hD, 1'b1, 32'h0, 32'h8000_0001, 2'd2, 5'd1);
      @(posedge clk); #1;
      n_checks++; if (result !== 32'hC000_0000) begin n_fail++; $display("FAIL asr_res got %h exp c0000000", result); end
      n_checks++; if (flags !== 4'b1010) begin n_fail++; $display("FAIL asr_flags got %b exp 1010", flags); end
      n_checks++; if (err !== 1'b0) begin n_fail++; $display("FAIL asr_err got %b exp 0", err); end
      drive(4'hD, 1'b1, 32'h0, 32'h8000_0001, 2'd3, 5'd1);
      @(posedge clk); #1;
      in_valid = 1'b0;
`ifdef ALU_PIPE_ROR_EN
      n_checks++; if (result !== 32'hC000_0000) begin n_fail++; $display("FAIL ror_res got %h exp c0000000", result); end
      n_checks++; if (err !== 1'b0) begin n_fail++; $display("FAIL ror_err got %b exp 0", err); end
`else
      n_checks++; if (result !== 32'h8000_0001) begin n_fail++; $display("FAIL ror_res got %h exp 80000001", result); end
      n_checks++; if (err !== 1'b1) begin n_fail++; $display("FAIL ror_err got %b exp 1", err); end
`endif
      n_checks++; if (flags !== 4'b1010) begin n_fail++; $display("FAIL ror_flags got %b exp 1010", flags); end
      @(posedge clk); #1;
   endtask

   task automatic test_stall;
      out_ready = 1'b0;
      drive(4'h4, 1'b1, 32'd1, 32'd2, 2'd0, 5'd0);
      @(posedge clk); #1;
      drive(4'h2, 1'b1, 32'd3, 32'd3, 2'd0, 5'd0);
      for (int i = 0; i < 3; i++) begin
         n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL stall_ready[%0d] got %b exp 0", i, in_ready); end
         n_checks++; if (result !== 32'd3 || out_valid !== 1'b1) begin n_fail++; $display("FAIL stall_hold[%0d] got %h/%b exp 3/1", i, result, out_valid); end
         n_checks++; if (flags !== 4'b0000) begin n_fail++; $display("FAIL stall_flags[%0d] got %b exp 0000", i, flags); end
         if (i < 2) begin @(posedge clk); #1; end
      end
      out_ready = 1'b1;
      #1;
      n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL stall_release got %b exp 1", in_ready); end
      @(posedge clk); #1;
      in_valid = 1'b0;
      n_checks++; if (result !== 32'd0) begin n_fail++; $display("FAIL stall_next_res got %h exp 0", result); end
      n_checks++; if (flags !== 4'b0110) begin n_fail++; $display("FAIL stall_next_flags got %b exp 0110", flags); end
      @(posedge clk); #1;
   endtask

   task automatic test_reset_mid_stall;
      out_ready = 1'b0;
      drive(4'h4, 1'b1, 32'd5, 32'd5, 2'd0, 5'd0);
      @(posedge clk); #1;
      drive(4'hF, 1'b1, 32'd0, 32'd0, 2'd0, 5'd0);
      @(posedge clk); #1;
      rst = 1'b1;
      #1;
      n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL rstst_ready got %b exp 0", in_ready); end
      @(posedge clk); #1;
      n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL rstst_valid got %b exp 0", out_valid); end
      n_checks++; if (flags !== 4'b0000) begin n_fail++; $display("FAIL rstst_flags got %b exp 0000", flags); end
      n_checks++; if (result !== 32'd0) begin n_fail++; $display("FAIL rstst_result got %h exp 0", result); end
      rst = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
      #1;
      n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL rstst_ready_after got %b exp 1", in_ready); end
      @(posedge clk); #1;
      n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL rstst_pending got %b exp 0", out_valid); end
   endtask

   function automatic logic [31:0] pick_operand();
      case ($urandom_range(0, 7))
         0: return 32'h0;
         1: return 32'hFFFF_FFFF;
         2: return 32'h7FFF_FFFF;
         3: return 32'h8000_0000;
         default: return $urandom;
      endcase
   endfunction

   task automatic test_random;
      logic        exp_v, exp_wb, exp_err, exp_rdy, iv, m_wb, m_err;
      logic [31:0] exp_res, m_res;
      logic [3:0]  m_flags, m_fl;
      exp_v = 1'b0; exp_wb = 1'b0; exp_err = 1'b0; exp_res = 32'd0; m_flags = 4'b0000;
      for (int i = 0; i < 400; i++) begin
         iv = ($urandom_range(0, 3) != 0);
         out_ready = ($urandom_range(0, 3) != 0);
         drive(4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)), pick_operand(), pick_operand(),
               2'($urandom_range(0, 3)), 5'($urandom_range(0, 31)));
         in_valid = iv;
         #1;
         exp_rdy = !exp_v || out_ready;
         n_checks++; if (in_ready !== exp_rdy) begin n_fail++; $display("FAIL rnd_ready[%0d] got %b exp %b", i, in_ready, exp_rdy); end
         if (iv && exp_rdy) begin
            model(op, s_bit, a, b, sh_type, sh_amt, m_flags, m_res, m_wb, m_err, m_fl);
            exp_v = 1'b1; exp_res = m_res; exp_wb = m_wb; exp_err = m_err; m_flags = m_fl;
         end else if (out_ready) begin
            exp_v = 1'b0;
         end
         @(posedge clk); #1;
         n_checks++; if (out_valid !== exp_v) begin n_fail++; $display("FAIL rnd_valid[%0d] got %b exp %b", i, out_valid, exp_v); end
         n_checks++; if (result !== exp_res) begin n_fail++; $display("FAIL rnd_result[%0d] op %h got %h exp %h", i, op, result, exp_res); end
         n_checks++; if ({wb, err} !== {exp_wb, exp_err}) begin n_fail++; $display("FAIL rnd_wb_err[%0d] got %b exp %b", i, {wb, err}, {exp_wb, exp_err}); end
         n_checks++; if (flags !== m_flags) begin n_fail++; $display("FAIL rnd_flags[%0d] op %h got %b exp %b", i, op, flags, m_flags); end
      end
      in_valid = 1'b0; out_ready = 1'b1;
   endtask

   initial begin
      test_reset();
      test_add_drain();
      test_back_to_back();
      test_cmp_sbc();
      test_shift();
      test_stall();
      test_reset_mid_stall();
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
